// File: rtl/qspi_flash_resp_if.sv
// rtl/qspi_flash_resp_if.sv - SPI pin bundle between QSPI controller (master) and flash target (slave)
interface qspi_flash_resp_if;
  logic       spi_sck;
  logic       spi_csn;
  logic       spi_sdo;
  logic       spi_sdi_o;
  logic       spi_sdi_en;
  logic [3:0] spi_q_o;
  logic [3:0] spi_q_en;

  modport master (
    output spi_sck, spi_csn, spi_sdo,
    input  spi_sdi_o, spi_sdi_en, spi_q_o, spi_q_en
  );

  modport slave (
    input  spi_sck, spi_csn, spi_sdo,
    output spi_sdi_o, spi_sdi_en, spi_q_o, spi_q_en
  );
endinterface

// File: rtl/qspi_flash_resp.sv
// rtl/qspi_flash_resp.sv - mode-0 serial-NOR flash target model oversampled on aclk
// Optional quad read (cmd 0x6B) enabled by defining QSPI_RESP_QUAD_EN.
module qspi_flash_resp #(
  parameter int DEPTH      = 64,
  parameter int ADDR_BYTES = 3,
  parameter int DUMMY_CLK  = 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  qspi_flash_resp_if.slave    spi,
  output logic                busy
);
  localparam int AW    = $clog2(DEPTH);
  localparam int ABITS = ADDR_BYTES * 8;

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, STAT, RDATA, WDATA, IGNORE, DUMMY, QDATA
  } state_t;

  state_t         state, state_nxt;
  logic [2:0]     sck_q;
  logic [1:0]     csn_q, sdo_q;
  logic [4:0]     bit_cnt;
  logic [2:0]     tx_cnt;
  logic [6:0]     rx_sh;
  logic [7:0]     cmd;
  logic [AW-1:0]  addr;
  logic           wel, pp_pend;
  logic           sdi_o, sdi_en;
  logic [7:0]     mem [DEPTH];

  // sck_q[1] is the synchronized level, sck_q[2] its previous value
  wire        sck_rise  = sck_q[1] & ~sck_q[2];
  wire        sck_fall  = ~sck_q[1] & sck_q[2];
  wire        csn_hi    = csn_q[1];
  wire        sdo_s     = sdo_q[1];
  wire [7:0]  rx_byte   = {rx_sh, sdo_s};
  wire        byte_done = sck_rise && (bit_cnt[2:0] == 3'd7);
  wire        addr_done = sck_rise && (bit_cnt == 5'(ABITS - 1));
  wire [7:0]  status    = {6'b0, wel, 1'b0};
  wire [7:0]  mem_rd    = mem[addr];
  wire [7:0]  tx_byte   = (state == STAT) ? status : mem_rd;

  assign spi.spi_sdi_o  = sdi_o;
  assign spi.spi_sdi_en = sdi_en;
  assign busy           = (state != IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (csn_hi) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = CMD;
        CMD: if (byte_done) begin
          case (rx_byte)
            8'h05:   state_nxt = STAT;
            8'h03:   state_nxt = ADDR;
            8'h02:   state_nxt = wel ? ADDR : IGNORE;
`ifdef QSPI_RESP_QUAD_EN
            8'h6B:   state_nxt = ADDR;
`endif
            default: state_nxt = IGNORE;
          endcase
        end
        ADDR: if (addr_done) begin
          if (cmd == 8'h03)      state_nxt = RDATA;
          else if (cmd == 8'h02) state_nxt = WDATA;
          else                   state_nxt = DUMMY;
        end
        DUMMY: if (sck_rise && bit_cnt == 5'(DUMMY_CLK - 1)) state_nxt = QDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sck_q   <= '0;
      csn_q   <= 2'b11;
      sdo_q   <= '0;
      bit_cnt <= '0;
      tx_cnt  <= '0;
      rx_sh   <= '0;
      cmd     <= '0;
      addr    <= '0;
      wel     <= 1'b0;
      pp_pend <= 1'b0;
      sdi_o   <= 1'b0;
      sdi_en  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
    end else begin
      sck_q <= {sck_q[1:0], spi.spi_sck};
      csn_q <= {csn_q[0], spi.spi_csn};
      sdo_q <= {sdo_q[0], spi.spi_sdo};
      // csn high overrides any bit or byte completing in the same cycle
      if (csn_hi) begin
        bit_cnt <= '0;
        tx_cnt  <= '0;
        sdi_en  <= 1'b0;
        if (pp_pend) begin
          wel     <= 1'b0;
          pp_pend <= 1'b0;
        end
      end else begin
        case (state)
          CMD: if (sck_rise) begin
            rx_sh   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (byte_done) begin
              cmd     <= rx_byte;
              bit_cnt <= '0;
              if (rx_byte == 8'h06) wel <= 1'b1;
              if (rx_byte == 8'h04) wel <= 1'b0;
              if (rx_byte == 8'h02 && wel) pp_pend <= 1'b1;
            end
          end
          ADDR: if (sck_rise) begin
            addr    <= {addr[AW-2:0], sdo_s};
            bit_cnt <= addr_done ? 5'd0 : bit_cnt + 5'd1;
          end
          DUMMY: if (sck_rise) bit_cnt <= bit_cnt + 5'd1;
          RDATA, STAT: if (sck_fall) begin
            sdi_o  <= tx_byte[3'd7 - tx_cnt];
            sdi_en <= 1'b1;
            tx_cnt <= tx_cnt + 3'd1;
            if (state == RDATA && tx_cnt == 3'd7) addr <= addr + AW'(1);
          end
          WDATA: if (sck_rise) begin
            rx_sh   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (byte_done) begin
              mem[addr] <= mem_rd & rx_byte;
              addr      <= addr + AW'(1);
              bit_cnt   <= '0;
            end
          end
`ifdef QSPI_RESP_QUAD_EN
          QDATA: if (sck_fall) begin
            tx_cnt <= tx_cnt + 3'd1;
            if (tx_cnt[0]) addr <= addr + AW'(1);
          end
`endif
          default: ;
        endcase
      end
    end
  end

`ifdef QSPI_RESP_QUAD_EN
  logic [3:0] q_o, q_en;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      q_o  <= '0;
      q_en <= '0;
    end else if (csn_hi) begin
      q_en <= '0;
    end else if (state == QDATA && sck_fall) begin
      q_o  <= tx_cnt[0] ? mem_rd[3:0] : mem_rd[7:4];
      q_en <= 4'hF;
    end
  end

  assign spi.spi_q_o  = q_o;
  assign spi.spi_q_en = q_en;
`else
  assign spi.spi_q_o  = 4'h0;
  assign spi.spi_q_en = 4'h0;
`endif
endmodule

// File: tb/tb_qspi_flash_resp.sv
// tb/tb_qspi_flash_resp.sv - directed self-checking bench for qspi_flash_resp
module tb_qspi_flash_resp;
  logic aclk, aresetn, busy;
  int   n_total = 0;
  int   n_pass  = 0;
  logic en_seen;

  qspi_flash_resp_if spi_bus ();

  qspi_flash_resp #(.DEPTH(64), .ADDR_BYTES(3), .DUMMY_CLK(8)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .spi     (spi_bus),
    .busy    (busy)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // sck half period 40 ns = 4 aclk; read data sampled just before each rise
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_bus.spi_sdo = tx[i];
      #40;
      rx[i]   = spi_bus.spi_sdi_o;
      en_seen = en_seen | spi_bus.spi_sdi_en | (|spi_bus.spi_q_en);
      spi_bus.spi_sck = 1'b1;
      #40;
      spi_bus.spi_sck = 1'b0;
    end
  endtask

  task automatic frame_start();
    spi_bus.spi_csn = 1'b0;
    #40;
  endtask

  task automatic frame_end();
    #40;
    spi_bus.spi_csn = 1'b1;
    #100;
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [7:0] d;
    xfer(a[23:16], d);
    xfer(a[15:8], d);
    xfer(a[7:0], d);
  endtask

  task automatic one_byte_cmd(input logic [7:0] op);
    logic [7:0] d;
    frame_start();
    xfer(op, d);
    frame_end();
  endtask

  task automatic rdsr(output logic [7:0] s);
    logic [7:0] d;
    frame_start();
    xfer(8'h05, d);
    xfer(8'h00, s);
    frame_end();
  endtask

  task automatic pp(input logic [23:0] a, input logic [7:0] b);
    logic [7:0] d;
    frame_start();
    xfer(8'h02, d);
    send_addr(a);
    xfer(b, d);
    frame_end();
  endtask

  task automatic read2(input logic [23:0] a, output logic [7:0] r0, output logic [7:0] r1);
    logic [7:0] d;
    frame_start();
    xfer(8'h03, d);
    send_addr(a);
    xfer(8'h00, r0);
    xfer(8'h00, r1);
    frame_end();
  endtask

  initial begin
    logic [7:0] d, r0, r1;
    aresetn = 1'b0;
    spi_bus.spi_sck = 1'b0;
    spi_bus.spi_csn = 1'b1;
    spi_bus.spi_sdo = 1'b0;
    en_seen = 1'b0;
    #50;
    check("rst_sdi_o",  {31'd0, spi_bus.spi_sdi_o},  32'd0);
    check("rst_sdi_en", {31'd0, spi_bus.spi_sdi_en}, 32'd0);
    check("rst_q_o",    {28'd0, spi_bus.spi_q_o},    32'd0);
    check("rst_q_en",   {28'd0, spi_bus.spi_q_en},   32'd0);
    check("rst_busy",   {31'd0, busy},               32'd0);
    aresetn = 1'b1;
    #50;

    // 1: READ of erased array, enables only after address
    frame_start();
    xfer(8'h03, d);
    xfer(8'h00, d);
    xfer(8'h00, d);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    en_seen = 1'b0;
    xfer(8'h00, d);
    check("sdi_en_during_addr", {31'd0, en_seen}, 32'd0);
    xfer(8'h00, r0);
    check("sdi_en_during_data", {31'd0, spi_bus.spi_sdi_en}, 32'd1);
    xfer(8'h00, r1);
    frame_end();
    check("read0_b0", {24'd0, r0}, 32'hFF);
    check("read0_b1", {24'd0, r1}, 32'hFF);
    check("sdi_en_after_csn", {31'd0, spi_bus.spi_sdi_en}, 32'd0);
    check("busy_after_csn", {31'd0, busy}, 32'd0);

    // 2: status register / WEL
    rdsr(d);                 check("rdsr_reset", {24'd0, d}, 32'h00);
    one_byte_cmd(8'h06);
    rdsr(d);                 check("rdsr_wren", {24'd0, d}, 32'h02);
    one_byte_cmd(8'h04);
    rdsr(d);                 check("rdsr_wrdi", {24'd0, d}, 32'h00);

    // 3: program two bytes and read back
    one_byte_cmd(8'h06);
    frame_start();
    xfer(8'h02, d);
    send_addr(24'h000010);
    xfer(8'h12, d);
    xfer(8'h34, d);
    frame_end();
    read2(24'h000010, r0, r1);
    check("pp_rd_b0", {24'd0, r0}, 32'h12);
    check("pp_rd_b1", {24'd0, r1}, 32'h34);
    rdsr(d);                 check("rdsr_after_pp", {24'd0, d}, 32'h00);

    // 4: PP without WEL is ignored; NOR AND semantics
    pp(24'h000020, 8'h00);
    read2(24'h000020, r0, r1);
    check("pp_no_wel", {24'd0, r0}, 32'hFF);
    one_byte_cmd(8'h06);
    pp(24'h000028, 8'h0F);
    one_byte_cmd(8'h06);
    pp(24'h000028, 8'hF3);
    read2(24'h000028, r0, r1);
    check("nor_and", {24'd0, r0}, 32'h03);

    // 5: address wrap and partial byte discard
    one_byte_cmd(8'h06);
    pp(24'h000000, 8'hA5);
    read2(24'h00003F, r0, r1);
    check("wrap_b0", {24'd0, r0}, 32'hFF);
    check("wrap_b1", {24'd0, r1}, 32'hA5);
    one_byte_cmd(8'h06);
    frame_start();
    xfer(8'h02, d);
    send_addr(24'h000038);
    xfer(8'h00, d);
    for (int i = 0; i < 3; i++) begin
      spi_bus.spi_sdo = 1'b0;
      #40;
      spi_bus.spi_sck = 1'b1;
      #40;
      spi_bus.spi_sck = 1'b0;
    end
    frame_end();
    read2(24'h000038, r0, r1);
    check("partial_b0", {24'd0, r0}, 32'h00);
    check("partial_b1", {24'd0, r1}, 32'hFF);
    rdsr(d);                 check("rdsr_after_partial", {24'd0, d}, 32'h00);

    // 6: unknown command keeps every driver off
    en_seen = 1'b0;
    frame_start();
    xfer(8'h9F, d);
    xfer(8'h00, d);
    xfer(8'h00, d);
    xfer(8'h00, d);
    frame_end();
    check("unknown_cmd_en", {31'd0, en_seen}, 32'd0);

`ifdef QSPI_RESP_QUAD_EN
    en_seen = 1'b0;
    frame_start();
    xfer(8'h6B, d);
    send_addr(24'h000010);
    for (int i = 0; i < 8; i++) begin
      #40;
      en_seen = en_seen | spi_bus.spi_sdi_en | (|spi_bus.spi_q_en);
      spi_bus.spi_sck = 1'b1;
      #40;
      spi_bus.spi_sck = 1'b0;
    end
    check("quad_dummy_en", {31'd0, en_seen}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #40;
      check("quad_nibble", {28'd0, spi_bus.spi_q_o}, 32'(i + 1));
      check("quad_en", {28'd0, spi_bus.spi_q_en}, 32'hF);
      spi_bus.spi_sck = 1'b1;
      #40;
      spi_bus.spi_sck = 1'b0;
    end
    frame_end();
    check("quad_en_after_csn", {28'd0, spi_bus.spi_q_en}, 32'h0);
`else
    en_seen = 1'b0;
    frame_start();
    xfer(8'h6B, d);
    send_addr(24'h000010);
    xfer(8'h00, d);
    xfer(8'h00, d);
    frame_end();
    check("qread_ignored", {31'd0, en_seen}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
